// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: register-address width and the writeback queue entry.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular write queue of wb_entry_t; also exposes every slot in oldest-first order
// so the parent can scan in-flight destinations.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  flush,
  input  logic                  push,
  input  wb_entry_t             din,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count,
  output wb_entry_t [DEPTH-1:0] entries
);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  wb_entry_t     mem [DEPTH];

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge CLK) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entries[k] = mem[rd_ptr + AW'(k)];
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: MEM/ALU producers feed a write queue drained one
// write per cycle. Optional forwarding lookup is built only when WB_FWD_EN is defined.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ALU_VALID,
  output logic                     ALU_READY,
  input  logic [REG_ADDR_W-1:0]    ALU_RD,
  input  logic [NBITS-1:0]         ALU_DATA,
  input  logic                     MEM_VALID,
  output logic                     MEM_READY,
  input  logic [REG_ADDR_W-1:0]    MEM_RD,
  input  logic [NBITS-1:0]         MEM_DATA,
  input  logic                     STALL,
  input  logic                     FLUSH,
  output logic                     WR,
  output logic [REG_ADDR_W-1:0]    ADD_WR,
  output logic [NBITS-1:0]         DATAIN,
  output logic [31:0]              PENDING_MASK,
`ifdef WB_FWD_EN
  input  logic [REG_ADDR_W-1:0]    FWD_ADDR,
  output logic                     FWD_HIT,
  output logic [NBITS-1:0]         FWD_DATA,
`endif
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (NBITS != XLEN) begin : g_width_check
    $error("writeback_unit: NBITS must equal riscv_pkg::XLEN");
  end

  logic                  full;
  logic                  empty;
  logic [CW-1:0]         fifo_count;
  wb_entry_t [DEPTH-1:0] q_entries;
  wb_entry_t             in_entry;
  logic                  can_accept;
  logic                  push;
  logic                  pop;

  // MEM has fixed priority, so ALU only sees READY when MEM is idle.
  assign can_accept = !full && !FLUSH;
  assign MEM_READY  = can_accept;
  assign ALU_READY  = can_accept && !MEM_VALID;

  always_comb begin
    in_entry = '0;
    if (MEM_VALID) begin
      in_entry.rd   = MEM_RD;
      in_entry.data = MEM_DATA;
    end else begin
      in_entry.rd   = ALU_RD;
      in_entry.data = ALU_DATA;
    end
  end

  // x0 writes complete the handshake but never occupy a slot.
  assign push = ((MEM_VALID && MEM_READY) || (ALU_VALID && ALU_READY)) && (in_entry.rd != '0);
  assign pop  = !empty && !STALL && !FLUSH;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .flush   (FLUSH),
    .push    (push),
    .din     (in_entry),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count),
    .entries (q_entries)
  );

  assign COUNT = fifo_count;

  // Output stage: registered register-file write port.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WR     <= 1'b0;
      ADD_WR <= '0;
      DATAIN <= '0;
    end else begin
      WR <= pop;
      if (pop) begin
        ADD_WR <= q_entries[0].rd;
        DATAIN <= q_entries[0].data;
      end
    end
  end

  always_comb begin
    PENDING_MASK = '0;
    if (WR) PENDING_MASK[ADD_WR] = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < fifo_count) PENDING_MASK[q_entries[k].rd] = 1'b1;
    end
    PENDING_MASK[0] = 1'b0;
  end

`ifdef WB_FWD_EN
  // Scan oldest to youngest so the last match (closest to the tail) wins.
  always_comb begin
    FWD_HIT  = 1'b0;
    FWD_DATA = '0;
    if (FWD_ADDR != '0) begin
      if (WR && (ADD_WR == FWD_ADDR)) begin
        FWD_HIT  = 1'b1;
        FWD_DATA = DATAIN;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((CW'(k) < fifo_count) && (q_entries[k].rd == FWD_ADDR)) begin
          FWD_HIT  = 1'b1;
          FWD_DATA = q_entries[k].data;
        end
      end
    end
  end
`endif

endmodule
